// File: rtl/mcu_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store RAM arbiter:
// state encoding, access-length codes, bus widths and length decoding.
package mcu_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] ZeroWord = '0;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The reserved code 2'b10 behaves as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      LEN_WORD: len_bytes = 3'd4;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mcu_arbiter_if.sv
// Requester and byte-wide RAM signals of the arbiter; slave is the arbiter
// side, master is the CPU/RAM side.
interface mcu_arbiter_if;
  import mcu_arbiter_pkg::*;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic [WORD_W-1:0] if_data_o;
  logic              if_done_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [WORD_W-1:0] mem_wdata_i;
  logic [WORD_W-1:0] mem_data_o;
  logic              mem_done_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic [BYTE_W-1:0] ram_data_o;
  logic              ram_we_o;
  logic [BYTE_W-1:0] ram_data_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_data_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_data_o, mem_done_o,
    output ram_addr_o, ram_data_o, ram_we_o,
    input  ram_data_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_data_o, if_done_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_data_o, mem_done_o,
    input  ram_addr_o, ram_data_o, ram_we_o,
    output ram_data_i,
    input  busy_o
  );

endinterface

// File: rtl/mcu_arbiter.sv
// Fixed-priority arbiter sharing one byte-wide RAM between instruction fetch
// and load/store; multi-byte accesses are serialised one byte per cycle.
module mcu_arbiter
  import mcu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mcu_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  logic [2:0]        cnt, len_n, cap_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q, buf_q, buf_asm, if_data_q, mem_data_q;
  logic [BYTE_W-1:0] wr_byte;
  logic              owner_if, grant, capture, last_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.mem_req_i)                        state_nxt = bus.mem_we_i ? MEM_WR : MEM_RD;
        else if (bus.if_req_i && !bus.if_flush_i) state_nxt = IF_RD;
      end
      IF_RD: begin
        if (bus.if_flush_i)   state_nxt = IDLE;
        else if (cnt == len_n) state_nxt = DONE;
      end
      MEM_RD:  if (cnt == len_n) state_nxt = DONE;
      MEM_WR:  if (cnt == len_n - 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so cycle cnt captures byte cnt-1.
  assign grant   = (state == IDLE) && (state_nxt != IDLE);
  assign capture = ((state == IF_RD && !bus.if_flush_i) || state == MEM_RD) && (cnt != 3'd0);
  assign last_rd = capture && (cnt == len_n);
  assign cap_idx = cnt - 3'd1;

  always_comb begin
    buf_asm = buf_q;
    wr_byte = wdata_q[BYTE_W-1:0];
    for (int b = 0; b < 4; b++) begin
      if (cap_idx == 3'(b)) buf_asm[8*b +: 8] = bus.ram_data_i;
      if (cnt == 3'(b))     wr_byte = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 3'd0;
      len_n      <= 3'd1;
      addr_q     <= ZeroWord;
      wdata_q    <= ZeroWord;
      owner_if   <= 1'b0;
      buf_q      <= ZeroWord;
      if_data_q  <= ZeroWord;
      mem_data_q <= ZeroWord;
    end else begin
      if (grant) begin
        addr_q   <= bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
        len_n    <= bus.mem_req_i ? len_bytes(bus.mem_len_i) : 3'd4;
        wdata_q  <= bus.mem_wdata_i;
        owner_if <= !bus.mem_req_i;
        buf_q    <= ZeroWord;
      end else if (capture) begin
        buf_q <= buf_asm;
      end
      if (last_rd) begin
        if (owner_if) if_data_q  <= buf_asm;
        else          mem_data_q <= buf_asm;
      end
      // Count only while remaining in a transfer state; any transition restarts at 0.
      cnt <= (state != IDLE && state_nxt == state) ? cnt + 3'd1 : 3'd0;
    end
  end

  assign bus.busy_o     = (state != IDLE);
  assign bus.ram_we_o   = (state == MEM_WR);
  assign bus.ram_data_o = (state == MEM_WR) ? wr_byte : '0;
  assign bus.ram_addr_o = (state == IF_RD || state == MEM_RD || state == MEM_WR)
                          ? addr_q + ADDR_W'(cnt) : ZeroWord;
  assign bus.if_done_o  = (state == DONE) && owner_if;
  assign bus.mem_done_o = (state == DONE) && !owner_if;
  assign bus.if_data_o  = if_data_q;
  assign bus.mem_data_o = mem_data_q;

endmodule

// File: doc/mcu_arbiter.md
MCU_ARBITER -- requirements
Module: mcu_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: if_req_i  in  1  fetch request, level, held until if_done_o or if_flush_i.
REQ-004 SHALL have port: if_addr_i  in  32  fetch byte address, stable while if_req_i high.
REQ-005 SHALL have port: if_flush_i  in  1  branch redirect; aborts any fetch in flight.
REQ-006 SHALL have port: if_data_o  out  32  fetched instruction word, little-endian.
REQ-007 SHALL have port: if_done_o  out  1  one-cycle fetch-complete pulse.
REQ-008 SHALL have port: mem_req_i  in  1  load/store request, level, held until mem_done_o.
REQ-009 SHALL have port: mem_we_i  in  1  1=store, 0=load.
REQ-010 SHALL have port: mem_len_i  in  2  00=byte, 01=half, 11=word; 10 treated as word.
REQ-011 SHALL have port: mem_addr_i  in  32  load/store byte address.
REQ-012 SHALL have port: mem_wdata_i  in  32  store data, byte k to addr+k.
REQ-013 SHALL have port: mem_data_o  out  32  load data, zero-extended, little-endian.
REQ-014 SHALL have port: mem_done_o  out  1  one-cycle load/store-complete pulse.
REQ-015 SHALL have port: ram_addr_o  out  32  byte address to RAM.
REQ-016 SHALL have port: ram_data_o  out  8  write byte to RAM.
REQ-017 SHALL have port: ram_we_o  out  1  RAM write enable.
REQ-018 SHALL have port: ram_data_i  in  8  RAM read byte, valid one cycle after address.
REQ-019 SHALL have port: busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL use states IDLE, IF_RD, MEM_RD, MEM_WR, DONE; byte counter cnt (3 bits) and length N (1, 2, 4).
REQ-021 In IDLE, mem_req_i high SHALL be granted, with fixed priority over if_req_i; no preemption once granted.
REQ-022 On grant, SHALL latch address, N, wdata, and we; ram_addr_o = addr; cnt = 0.
REQ-023 Read: byte k address driven in cycle k; byte k captured from ram_data_i in cycle k+1 into bits [8k+7:8k]; after the last capture, SHALL go to DONE.
REQ-024 Read latency: done pulse SHALL be visible N+2 cycles after the edge that samples the request in IDLE (word fetch = 6).
REQ-025 Write: ram_we_o high for exactly N consecutive cycles, byte k on ram_data_o with ram_addr_o = addr+k; then DONE; done visible N+1 cycles after grant edge.
REQ-026 DONE SHALL last one cycle: assert the relevant done, hold its data output, ignore requests, then return to IDLE.
REQ-027 Minimum spacing: one dead IDLE cycle between successive transactions; requester must drop req in its done cycle or it is re-granted.
REQ-028 if_data_o/mem_data_o SHALL hold their value until the next done of the same requester; unused upper bytes read as 0.
REQ-029 Address arithmetic SHALL be addr+cnt modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
REQ-030 if_flush_i high during IF_RD SHALL return the block to IDLE next edge, with no if_done_o and ram_we_o low.
REQ-031 if_flush_i in IDLE or DONE SHALL suppress an IF grant that cycle.
REQ-032 if_flush_i during MEM_RD or MEM_WR SHALL have no effect.
REQ-033 ram_we_o SHALL never be high outside MEM_WR.

Reset
REQ-034 rst low SHALL asynchronously force state IDLE, cnt 0, and all outputs 0.
REQ-035 A transaction in flight at reset SHALL be dropped, with no done pulse and no further RAM writes.
REQ-036 The first grant SHALL be possible on the first edge after rst deasserts.

Structure
REQ-037 State encodings, mem_len codes, ZeroWord, and bus-width macros SHALL live in the shared defines package.
REQ-038 SHALL be a single module with no sub-modules; byte assembly is inline.

Verification
REQ-039 Word fetch addr 0x100, RAM bytes 13 05 00 00 -> if_data_o=0x00000513, if_done_o pulses 6 cycles after the request edge, ram_we_o stays 0.
REQ-040 if_req_i and mem_req_i (load byte 0x200=0xAB) rise together -> mem served first, mem_data_o=0x000000AB; IF granted after DONE+IDLE.
REQ-041 Store half 0xBEEF to 0x1FF -> writes EF@0x1FF then BE@0x200, ram_we_o high exactly 2 cycles, mem_done_o pulses 3 cycles after grant.
REQ-042 if_flush_i at cnt=2 of a fetch -> IDLE next cycle, no if_done_o; new fetch from the redirect address completes normally.
REQ-043 Word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order.
REQ-044 rst low mid-store at cnt=1 -> ram_we_o drops immediately, no mem_done_o; after release, IDLE and busy_o=0.
